// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM controller/arbiter.
// Byte-lane count is derived from the 2-bit MEM-stage length code.
package mem_ctrl_pkg;

  localparam int MC_ADDR_W     = 32;
  localparam int MC_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_READ,
    MC_WRITE,
    MC_DONE
  } mc_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } mc_owner_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  // The reserved code 2'b10 falls through to a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   len_bytes = 3'd1;
      LEN_H:   len_bytes = 3'd2;
      default: len_bytes = 3'(MC_WORD_BYTES);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one 8-bit RAM port between IF fetches and MEM loads/stores, moving one byte per cycle.
// Words are assembled/disassembled little-endian; every output is registered.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  output logic [31:0]       o_if_inst,
  output logic [ADDR_W-1:0] o_if_pc_back,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [1:0]        i_mem_len,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  output logic              o_mem_done,
  output logic [31:0]       o_mem_rdata,
  input  logic [7:0]        i_ram_din,
  output logic [7:0]        o_ram_dout,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic              o_ram_wr
);

  mc_state_t         r_state;
  mc_owner_t         r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_nbytes;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [2:0]        r_cnt;

  logic [2:0]        w_next_cnt;
  logic [1:0]        w_next_idx;
  logic [1:0]        w_prev_idx;
  logic [ADDR_W-1:0] w_next_addr;
  logic [31:0]       w_data_upd;
  logic [7:0]        w_wbyte;
  logic              w_grant_if;

  // r_cnt is the index of the byte whose address is on ram_a this cycle;
  // reads land one cycle later, so the byte captured now is r_cnt-1.
  assign w_next_cnt  = r_cnt + 3'd1;
  assign w_next_idx  = w_next_cnt[1:0];
  assign w_prev_idx  = 2'(r_cnt - 3'd1);
  assign w_next_addr = r_addr + ADDR_W'(w_next_cnt);
  assign w_data_upd  = r_data | ({24'd0, i_ram_din} << {w_prev_idx, 3'b000});
  assign w_wbyte     = r_wdata[{w_next_idx, 3'b000} +: 8];
  assign w_grant_if  = i_if_req && !i_flush && !i_mem_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= MC_IDLE;
      r_owner      <= OWN_IF;
      r_addr       <= '0;
      r_nbytes     <= '0;
      r_wdata      <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
      o_if_done    <= 1'b0;
      o_if_inst    <= '0;
      o_if_pc_back <= '0;
      o_mem_done   <= 1'b0;
      o_mem_rdata  <= '0;
      o_ram_dout   <= '0;
      o_ram_a      <= '0;
      o_ram_wr     <= 1'b0;
    end else begin
      o_if_done  <= 1'b0;
      o_mem_done <= 1'b0;
      case (r_state)
        MC_IDLE: begin
          if (i_mem_req) begin
            r_owner  <= OWN_MEM;
            r_addr   <= i_mem_addr;
            r_nbytes <= len_bytes(i_mem_len);
            r_wdata  <= i_mem_wdata;
            r_data   <= '0;
            r_cnt    <= '0;
            o_ram_a  <= i_mem_addr;
            if (i_mem_we) begin
              r_state    <= MC_WRITE;
              o_ram_wr   <= 1'b1;
              o_ram_dout <= i_mem_wdata[7:0];
            end else begin
              r_state <= MC_READ;
            end
          end else if (w_grant_if) begin
            r_owner  <= OWN_IF;
            r_addr   <= i_if_addr;
            r_nbytes <= 3'(MC_WORD_BYTES);
            r_wdata  <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            o_ram_a  <= i_if_addr;
            r_state  <= MC_READ;
          end
        end

        MC_READ: begin
          if (r_owner == OWN_IF && i_flush) begin
            r_state <= MC_IDLE;
          end else begin
            if (r_cnt != 3'd0) begin
              r_data <= w_data_upd;
            end
            if (r_cnt == r_nbytes) begin
              r_state <= MC_DONE;
              if (r_owner == OWN_IF) begin
                o_if_done    <= 1'b1;
                o_if_inst    <= w_data_upd;
                o_if_pc_back <= r_addr;
              end else begin
                o_mem_done  <= 1'b1;
                o_mem_rdata <= w_data_upd;
              end
            end else begin
              r_cnt <= w_next_cnt;
              if (w_next_cnt != r_nbytes) begin
                o_ram_a <= w_next_addr;
              end
            end
          end
        end

        MC_WRITE: begin
          if (w_next_cnt == r_nbytes) begin
            r_state    <= MC_DONE;
            o_mem_done <= 1'b1;
            o_ram_wr   <= 1'b0;
            o_ram_dout <= '0;
          end else begin
            r_cnt      <= w_next_cnt;
            o_ram_a    <= w_next_addr;
            o_ram_dout <= w_wbyte;
          end
        end

        MC_DONE: begin
          r_state <= MC_IDLE;
        end

        default: begin
          r_state <= MC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a transaction-level model predicts every cycle's outputs,
// directed transactions add hand-computed latency/data literals.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic        memReq = 1'b0;
  logic        memWe = 1'b0;
  logic [1:0]  memLen = 2'b00;
  logic [31:0] memAddr = '0;
  logic [31:0] memWdata = '0;
  logic [7:0]  ramDin = '0;

  logic        oIfDone;
  logic [31:0] oIfInst;
  logic [31:0] oIfPc;
  logic        oMemDone;
  logic [31:0] oMemRdata;
  logic [7:0]  oRamDout;
  logic [31:0] oRamA;
  logic        oRamWr;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  mem_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_if_req    (ifReq),
    .i_if_addr   (ifAddr),
    .o_if_done   (oIfDone),
    .o_if_inst   (oIfInst),
    .o_if_pc_back(oIfPc),
    .i_mem_req   (memReq),
    .i_mem_we    (memWe),
    .i_mem_len   (memLen),
    .i_mem_addr  (memAddr),
    .i_mem_wdata (memWdata),
    .o_mem_done  (oMemDone),
    .o_mem_rdata (oMemRdata),
    .i_ram_din   (ramDin),
    .o_ram_dout  (oRamDout),
    .o_ram_a     (oRamA),
    .o_ram_wr    (oRamWr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Bench-side RAM: read data appears one cycle after the address.
  logic [7:0] ram [logic [31:0]];
  function automatic logic [7:0] ramRd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  always @(posedge clk) ramDin <= ramRd(oRamA);
  always @(negedge clk) if (oRamWr) ram[oRamA] = oRamDout;

  // Reference model: whole transactions are scheduled onto absolute cycle numbers.
  logic [7:0]  gold [logic [31:0]];
  bit          eWr [int];
  logic [31:0] eA [int];
  logic [7:0]  eDout [int];
  bit          eIfDone [int];
  logic [31:0] eIfInst [int];
  logic [31:0] eIfPc [int];
  bit          eMemDone [int];
  logic [31:0] eMemRd [int];
  int          busyEnd = -1;
  int          clearAt = -1;
  bit          busyIsIf = 1'b0;
  bit          modelOn = 1'b0;
  logic [31:0] mIfInst = '0;
  logic [31:0] mIfPc = '0;
  logic [31:0] mMemRd = '0;

  function automatic logic [7:0] goldRd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : 8'h00;
  endfunction

  function automatic int lenBytes(input logic [1:0] l);
    if (l == 2'b00) return 1;
    if (l == 2'b01) return 2;
    return 4;
  endfunction

  task automatic dropSchedule();
    eWr.delete(); eA.delete(); eDout.delete();
    eIfDone.delete(); eIfInst.delete(); eIfPc.delete();
    eMemDone.delete(); eMemRd.delete();
  endtask

  task automatic schedule(input int g, input bit isIf, input bit we, input logic [31:0] addr,
                          input int n, input logic [31:0] wdata);
    logic [31:0] data = '0;
    logic [31:0] a;
    int doneCyc;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      eA[g + 1 + i] = a;
      if (we) begin
        eWr[g + 1 + i]   = 1'b1;
        eDout[g + 1 + i] = wdata[8*i +: 8];
      end else begin
        data = data | ({24'd0, goldRd(a)} << (8 * i));
      end
    end
    doneCyc = we ? g + n + 1 : g + n + 2;
    if (isIf) begin
      eIfDone[doneCyc] = 1'b1;
      eIfInst[doneCyc] = data;
      eIfPc[doneCyc]   = addr;
    end else begin
      eMemDone[doneCyc] = 1'b1;
      if (!we) eMemRd[doneCyc] = data;
    end
    busyEnd  = doneCyc;
    busyIsIf = isIf;
  endtask

  always @(negedge clk) begin
    if (cyc == clearAt) begin
      mIfInst = '0;
      mIfPc   = '0;
      mMemRd  = '0;
    end
    if (eIfDone.exists(cyc)) begin
      mIfInst = eIfInst[cyc];
      mIfPc   = eIfPc[cyc];
    end
    if (eMemRd.exists(cyc)) mMemRd = eMemRd[cyc];
    if (eWr.exists(cyc)) gold[eA[cyc]] = eDout[cyc];
    if (modelOn) begin
      checkOutput("ram_wr", 32'(oRamWr), 32'(eWr.exists(cyc)));
      checkOutput("ram_dout", 32'(oRamDout), eWr.exists(cyc) ? 32'(eDout[cyc]) : 32'd0);
      if (eA.exists(cyc)) checkOutput("ram_a", oRamA, eA[cyc]);
      checkOutput("if_done", 32'(oIfDone), 32'(eIfDone.exists(cyc)));
      checkOutput("mem_done", 32'(oMemDone), 32'(eMemDone.exists(cyc)));
      checkOutput("if_inst", oIfInst, mIfInst);
      checkOutput("if_pc_back", oIfPc, mIfPc);
      checkOutput("mem_rdata", oMemRdata, mMemRd);
    end
    if (rst) begin
      dropSchedule();
      busyEnd = cyc;
      clearAt = cyc + 1;
      modelOn = 1'b1;
    end else if (cyc > busyEnd) begin
      if (memReq) schedule(cyc, 1'b0, memWe, memAddr, lenBytes(memLen), memWdata);
      else if (ifReq && !flush) schedule(cyc, 1'b1, 1'b0, ifAddr, 4, 32'd0);
    end else if (busyIsIf && flush) begin
      dropSchedule();
      busyEnd = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]  = d;
    gold[a] = d;
  endtask

  task automatic waitDone(input bit isIf, input int g, input int limit, output int lat);
    lat = -1;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (isIf ? oIfDone : oMemDone) begin
        lat = cyc - g;
        return;
      end
    end
  endtask

  task automatic applyStimulusFetch(input logic [31:0] addr, input int expLat,
                                    input logic [31:0] expInst, input string name,
                                    input bit flushFirst);
    int g = cyc;
    int lat;
    ifReq  = 1'b1;
    ifAddr = addr;
    flush  = flushFirst;
    if (flushFirst) begin
      tick();
      flush = 1'b0;
    end
    waitDone(1'b1, g, 20, lat);
    ifReq = 1'b0;
    checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_inst"}, oIfInst, expInst);
    checkOutput({name, "_pc"}, oIfPc, addr);
    tick();
  endtask

  task automatic applyStimulusMem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int expLat,
                                  input logic [31:0] expRd, input string name);
    int g = cyc;
    int lat;
    memReq   = 1'b1;
    memWe    = we;
    memLen   = len;
    memAddr  = addr;
    memWdata = wdata;
    waitDone(1'b0, g, 20, lat);
    memReq = 1'b0;
    checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
    if (!we) checkOutput({name, "_rdata"}, oMemRdata, expRd);
    tick();
  endtask

  initial begin
    int g;
    int lat;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h104, 8'h93); preload(32'h105, 8'h00); preload(32'h106, 8'h10); preload(32'h107, 8'h00);
    preload(32'h200, 8'hB3); preload(32'h201, 8'h81); preload(32'h202, 8'h20); preload(32'h203, 8'h00);
    preload(32'h40, 8'h80);
    preload(32'hFFFFFFFF, 8'h34); preload(32'h0, 8'h12);

    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_if_done", 32'(oIfDone), 32'd0);
    checkOutput("rst_ram_wr", 32'(oRamWr), 32'd0);
    checkOutput("rst_ram_a", oRamA, 32'd0);
    checkOutput("rst_mem_rdata", oMemRdata, 32'd0);
    tick();

    applyStimulusFetch(32'h100, 6, 32'h00000513, "fetch", 1'b0);

    applyStimulusMem(1'b1, 2'b11, 32'h20, 32'hDEADBEEF, 5, 32'd0, "sw");
    checkOutput("sw_ram", {ramRd(32'h23), ramRd(32'h22), ramRd(32'h21), ramRd(32'h20)}, 32'hDEADBEEF);

    // Contention: MEM wins, IF is granted in the IDLE cycle after MEM's DONE.
    g = cyc;
    ifReq = 1'b1; ifAddr = 32'h104;
    memReq = 1'b1; memWe = 1'b0; memLen = 2'b00; memAddr = 32'h40;
    waitDone(1'b0, g, 20, lat);
    memReq = 1'b0;
    checkOutput("arb_mem_lat", 32'(lat), 32'd3);
    checkOutput("arb_mem_rdata", oMemRdata, 32'h00000080);
    checkOutput("arb_if_waiting", 32'(oIfDone), 32'd0);
    g = cyc;
    waitDone(1'b1, g, 20, lat);
    ifReq = 1'b0;
    checkOutput("arb_if_lat", 32'(lat), 32'd7);
    checkOutput("arb_if_inst", oIfInst, 32'h00100093);
    checkOutput("arb_if_pc", oIfPc, 32'h104);
    tick();

    // Flush in cycle 3 of a fetch; a fetch issued in cycle 4 must be granted at once.
    g = cyc;
    ifReq = 1'b1; ifAddr = 32'h100;
    repeat (3) tick();
    flush = 1'b1; ifReq = 1'b0;
    tick();
    flush = 1'b0;
    checkOutput("flush_no_done", 32'(oIfDone), 32'd0);
    checkOutput("flush_inst_hold", oIfInst, 32'h00100093);
    applyStimulusFetch(32'h200, 6, 32'h002081B3, "refetch", 1'b0);
    applyStimulusFetch(32'h104, 7, 32'h00100093, "flush_idle", 1'b1);

    applyStimulusMem(1'b0, 2'b11, 32'h100, 32'd0, 6, 32'h00000513, "lw");
    applyStimulusMem(1'b0, 2'b10, 32'h200, 32'd0, 6, 32'h002081B3, "lres");
    applyStimulusMem(1'b0, 2'b01, 32'hFFFFFFFF, 32'd0, 4, 32'h00001234, "lh_wrap");

    // Reset in cycle 2 of a word store.
    g = cyc;
    memReq = 1'b1; memWe = 1'b1; memLen = 2'b11; memAddr = 32'h60; memWdata = 32'h11223344;
    repeat (2) tick();
    rst = 1'b1; memReq = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_ram_wr", 32'(oRamWr), 32'd0);
    checkOutput("rst_mid_mem_done", 32'(oMemDone), 32'd0);
    checkOutput("rst_mid_if_inst", oIfInst, 32'd0);
    repeat (4) tick();
    checkOutput("rst_mid_bytes", {16'd0, ramRd(32'h61), ramRd(32'h60)}, 32'h00003344);
    checkOutput("rst_mid_no_byte2", 32'(ram.exists(32'h62)), 32'd0);

    applyStimulusFetch(32'h100, 6, 32'h00000513, "post_rst", 1'b0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
